// File: rtl/vp_vload_line_seq.sv
// Vector-load line sequencer: turns one (base, line count) command into a
// stream of cache-line reads bounded by an outstanding limit, forwards each
// response to writeback tagged with its line index, and pulses done at the end.
// Optional feature macro: VP_VLOAD_SEQ_PERF_EN (request-stall cycle counter).

package vp_vload_line_seq_pkg;
  localparam int unsigned VP_PADDR_W = 56;
  localparam int unsigned VP_SRC_W   = 4;
  localparam int unsigned VP_TID_W   = 16;
  localparam int unsigned VP_DATA_W  = 64;

  localparam logic [VP_SRC_W-1:0] VP_VLOAD_SRC_ID = 4'h5;

  typedef struct packed {
    logic [VP_SRC_W-1:0] src;
    logic [VP_TID_W-1:0] tid;
  } cpu_cache_if_tid_t;

  typedef struct packed {
    cpu_cache_if_tid_t       req_tid;
    logic [VP_PADDR_W-1:0]   addr;
  } cpu_cache_if_req_t;

  typedef struct packed {
    cpu_cache_if_tid_t       req_tid;
    logic [VP_DATA_W-1:0]    data;
  } cpu_cache_if_resp_t;
endpackage

module vp_vload_line_seq
  import vp_vload_line_seq_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned ADDR_W          = 56,
  parameter int unsigned LINE_BYTES      = 64
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_base_addr,
  input  logic [CNT_W-1:0]    cmd_num_lines,
  output logic                tlb_rd_req_valid,
  output cpu_cache_if_req_t   tlb_rd_req,
  input  logic                tlb_rd_req_ready,
  input  logic                tlb_rd_resp_valid,
  input  cpu_cache_if_resp_t  tlb_rd_resp,
  output logic                tlb_rd_resp_ready,
  output logic                wb_valid,
  output cpu_cache_if_resp_t  wb_resp,
  output logic [CNT_W-1:0]    wb_idx,
  input  logic                wb_ready,
  output logic                busy,
  output logic                done,
  output logic                err_unexp,
  output logic [31:0]         perf_stall_cnt
);

  localparam int unsigned       OFF_W    = $clog2(LINE_BYTES);
  localparam int unsigned       CTR_W    = CNT_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);
  localparam logic [CTR_W-1:0]  MAX_OUT  = CTR_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CTR_W-1:0]   num_q, num_d;
  logic [CTR_W-1:0]   issued_q, issued_d;
  logic [CTR_W-1:0]   returned_q, returned_d;
  logic [CTR_W-1:0]   outst_q, outst_d;
  logic               err_q, err_d;
  logic               req_hs, resp_hs;

  // State and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      outst_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      outst_q    <= outst_d;
      err_q      <= err_d;
    end
  end

  // Next-state, counter updates and handshake signals
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    num_d             = num_q;
    issued_d          = issued_q;
    returned_d        = returned_q;
    outst_d           = outst_q;
    err_d             = err_q;
    cmd_ready         = 1'b0;
    tlb_rd_req_valid  = 1'b0;
    tlb_rd_resp_ready = 1'b1;
    wb_valid          = 1'b0;
    req_hs            = 1'b0;
    resp_hs           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          base_d     = cmd_base_addr & ~OFF_MASK;
          num_d      = CTR_W'(cmd_num_lines);
          issued_d   = '0;
          returned_d = '0;
          outst_d    = '0;
          err_d      = 1'b0;
          state_d    = (cmd_num_lines == '0) ? ST_DONE : ST_ISSUE;
        end
        // A response with nothing in flight is dropped and flagged
        if (tlb_rd_resp_valid) begin
          err_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        tlb_rd_req_valid  = (issued_q < num_q) && (outst_q < MAX_OUT);
        tlb_rd_resp_ready = wb_ready;
        wb_valid          = tlb_rd_resp_valid;
        req_hs            = tlb_rd_req_valid && tlb_rd_req_ready;
        resp_hs           = tlb_rd_resp_valid && wb_ready;
        issued_d          = issued_q + CTR_W'(req_hs);
        returned_d        = returned_q + CTR_W'(resp_hs);
        outst_d           = outst_q + CTR_W'(req_hs) - CTR_W'(resp_hs);
        if (returned_q == num_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request payload derived from the issue counter; stable while stalled
  always_comb begin
    tlb_rd_req             = '0;
    tlb_rd_req.req_tid.src = VP_VLOAD_SRC_ID;
    tlb_rd_req.req_tid.tid = VP_TID_W'(issued_q);
    tlb_rd_req.addr        = VP_PADDR_W'(base_q + (ADDR_W'(issued_q) << OFF_W));
  end

  assign wb_resp   = tlb_rd_resp;
  assign wb_idx    = CNT_W'(tlb_rd_resp.req_tid.tid);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err_unexp = err_q;

`ifdef VP_VLOAD_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles a request waits on a stalled channel
  always_comb begin
    perf_d = perf_q;
    if (tlb_rd_req_valid && !tlb_rd_req_ready && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Stall counter register, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_vp_vload_line_seq.sv
// Directed self-checking bench for vp_vload_line_seq (default parameters).
module tb_vp_vload_line_seq;
  import vp_vload_line_seq_pkg::*;

  logic               clk;
  logic               rstn;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [55:0]        cmd_base_addr;
  logic [7:0]         cmd_num_lines;
  logic               tlb_rd_req_valid;
  cpu_cache_if_req_t  tlb_rd_req;
  logic               tlb_rd_req_ready;
  logic               tlb_rd_resp_valid;
  cpu_cache_if_resp_t tlb_rd_resp;
  logic               tlb_rd_resp_ready;
  logic               wb_valid;
  cpu_cache_if_resp_t wb_resp;
  logic [7:0]         wb_idx;
  logic               wb_ready;
  logic               busy;
  logic               done;
  logic               err_unexp;
  logic [31:0]        perf_stall_cnt;

  int checks = 0;
  int errors = 0;

  vp_vload_line_seq dut (
    .clk               (clk),
    .rstn              (rstn),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_base_addr     (cmd_base_addr),
    .cmd_num_lines     (cmd_num_lines),
    .tlb_rd_req_valid  (tlb_rd_req_valid),
    .tlb_rd_req        (tlb_rd_req),
    .tlb_rd_req_ready  (tlb_rd_req_ready),
    .tlb_rd_resp_valid (tlb_rd_resp_valid),
    .tlb_rd_resp       (tlb_rd_resp),
    .tlb_rd_resp_ready (tlb_rd_resp_ready),
    .wb_valid          (wb_valid),
    .wb_resp           (wb_resp),
    .wb_idx            (wb_idx),
    .wb_ready          (wb_ready),
    .busy              (busy),
    .done              (done),
    .err_unexp         (err_unexp),
    .perf_stall_cnt    (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_resp(input logic v, input int unsigned tid);
    tlb_rd_resp_valid       = v;
    tlb_rd_resp.req_tid.src = VP_VLOAD_SRC_ID;
    tlb_rd_resp.req_tid.tid = 16'(tid);
    tlb_rd_resp.data        = 64'hDA7A_0000 + 64'(tid);
  endtask

  // Handshake one command; returns #1 after the edge that accepted it
  task automatic send_cmd(input logic [55:0] base, input logic [7:0] num);
    cyc();
    cmd_valid     = 1'b1;
    cmd_base_addr = base;
    cmd_num_lines = num;
    settle();
    chk("cmd_ready_before_hs", 64'(cmd_ready), 64'd1);
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [55:0] t1_addr [4];
    int          seq [4];
    int          got_idx [4];
    int          beats;
    int          dones;
    int          p;

    t1_addr = '{56'h1000_0040, 56'h1000_0080, 56'h1000_00C0, 56'h1000_0100};
    seq     = '{2, 0, 3, 1};

    rstn             = 1'b0;
    cmd_valid        = 1'b0;
    cmd_base_addr    = '0;
    cmd_num_lines    = '0;
    tlb_rd_req_ready = 1'b1;
    wb_ready         = 1'b1;
    set_resp(1'b0, 0);

    // Reset values
    #3;
    chk("rst_cmd_ready",  64'(cmd_ready), 64'd1);
    chk("rst_resp_ready", 64'(tlb_rd_resp_ready), 64'd1);
    chk("rst_req_valid",  64'(tlb_rd_req_valid), 64'd0);
    chk("rst_wb_valid",   64'(wb_valid), 64'd0);
    chk("rst_done",       64'(done), 64'd0);
    chk("rst_busy",       64'(busy), 64'd0);
    chk("rst_err",        64'(err_unexp), 64'd0);
    chk("rst_perf",       64'(perf_stall_cnt), 64'd0);
    cyc();
    rstn = 1'b1;

    // Four lines, responses three cycles after each request
    send_cmd(56'h1000_0040, 8'd4);
    beats = 0;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (c >= 3 && c <= 6) set_resp(1'b1, 32'(c - 3));
      else                  set_resp(1'b0, 0);
      settle();
      chk("t1_req_valid", 64'(tlb_rd_req_valid), 64'(c <= 3));
      if (c <= 3) begin
        chk("t1_req_addr", 64'(tlb_rd_req.addr), 64'(t1_addr[c]));
        chk("t1_req_tid",  64'(tlb_rd_req.req_tid.tid), 64'(c));
        chk("t1_req_src",  64'(tlb_rd_req.req_tid.src), 64'(VP_VLOAD_SRC_ID));
      end
      if (c >= 3 && c <= 6) begin
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_wb_idx",   64'(wb_idx), 64'(c - 3));
        chk("t1_wb_data",  wb_resp.data, 64'hDA7A_0000 + 64'(c - 3));
        if (wb_valid) beats++;
      end
      chk("t1_done", 64'(done), 64'(c == 8));
      if (done) dones++;
      if (c == 9) chk("t1_cmd_ready_end", 64'(cmd_ready), 64'd1);
      cyc();
    end
    chk("t1_beats", 64'(beats), 64'd4);
    chk("t1_done_count", 64'(dones), 64'd1);

    // Eight lines with responses withheld: limit of four in flight
    send_cmd(56'h0, 8'd8);
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("t2_req_valid_fill", 64'(tlb_rd_req_valid), 64'(c < 4));
      if (c < 4) chk("t2_req_tid_fill", 64'(tlb_rd_req.req_tid.tid), 64'(c));
      cyc();
    end
    for (int k = 0; k < 4; k++) begin
      set_resp(1'b1, 32'(k));
      settle();
      chk("t2_req_valid_at_resp", 64'(tlb_rd_req_valid), 64'd0);
      chk("t2_wb_idx", 64'(wb_idx), 64'(k));
      cyc();
      set_resp(1'b0, 0);
      settle();
      chk("t2_req_valid_after", 64'(tlb_rd_req_valid), 64'd1);
      chk("t2_req_tid", 64'(tlb_rd_req.req_tid.tid), 64'(4 + k));
      chk("t2_req_addr", 64'(tlb_rd_req.addr), 64'((4 + k) * 64));
      cyc();
      settle();
      chk("t2_req_valid_one_only", 64'(tlb_rd_req_valid), 64'd0);
      cyc();
    end
    for (int k = 4; k < 8; k++) begin
      set_resp(1'b1, 32'(k));
      settle();
      chk("t2_drain_req_valid", 64'(tlb_rd_req_valid), 64'd0);
      chk("t2_drain_wb_valid", 64'(wb_valid), 64'd1);
      cyc();
    end
    set_resp(1'b0, 0);
    settle();
    chk("t2_done_early", 64'(done), 64'd0);
    chk("t2_busy", 64'(busy), 64'd1);
    cyc();
    settle();
    chk("t2_done", 64'(done), 64'd1);
    cyc();
    settle();
    chk("t2_done_clear", 64'(done), 64'd0);
    chk("t2_cmd_ready", 64'(cmd_ready), 64'd1);

    // Zero-line command
    send_cmd(56'h40, 8'd0);
    settle();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_req_valid", 64'(tlb_rd_req_valid), 64'd0);
    chk("t3_cmd_ready_busy", 64'(cmd_ready), 64'd0);
    cyc();
    settle();
    chk("t3_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t3_done_clear", 64'(done), 64'd0);

    // Out-of-order responses with writeback backpressure
    send_cmd(56'h2000, 8'd4);
    for (int c = 0; c < 4; c++) begin
      settle();
      chk("t4_req_valid", 64'(tlb_rd_req_valid), 64'd1);
      chk("t4_req_tid", 64'(tlb_rd_req.req_tid.tid), 64'(c));
      cyc();
    end
    p = 0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      wb_ready = c[0];
      if (p < 4) set_resp(1'b1, 32'(seq[p]));
      else       set_resp(1'b0, 0);
      settle();
      if (p < 4) begin
        chk("t4_wb_valid", 64'(wb_valid), 64'd1);
        chk("t4_wb_idx", 64'(wb_idx), 64'(seq[p]));
        chk("t4_resp_ready", 64'(tlb_rd_resp_ready), 64'(wb_ready));
        if (wb_ready) begin
          got_idx[p] = int'(wb_idx);
          p++;
        end
      end
      chk("t4_done", 64'(done), 64'(c == 9));
      if (done) dones++;
      cyc();
    end
    wb_ready = 1'b1;
    chk("t4_beats", 64'(p), 64'd4);
    chk("t4_done_count", 64'(dones), 64'd1);
    for (int i = 0; i < 4; i++) chk("t4_idx_order", 64'(got_idx[i]), 64'(seq[i]));

    // Address wrap, then reset mid-command
    send_cmd(56'hFF_FFFF_FFFF_FFC0, 8'd2);
    settle();
    chk("t5_addr0", 64'(tlb_rd_req.addr), 64'h00FF_FFFF_FFFF_FFC0);
    cyc();
    settle();
    chk("t5_addr1_wrap", 64'(tlb_rd_req.addr), 64'd0);
    chk("t5_tid1", 64'(tlb_rd_req.req_tid.tid), 64'd1);
    cyc();
    settle();
    chk("t5_busy_pre_rst", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t5_rst_req_valid", 64'(tlb_rd_req_valid), 64'd0);
    chk("t5_rst_done", 64'(done), 64'd0);
    chk("t5_rst_err", 64'(err_unexp), 64'd0);
    chk("t5_rst_resp_ready", 64'(tlb_rd_resp_ready), 64'd1);
    cyc();
    rstn = 1'b1;
    cyc();
    set_resp(1'b1, 1);
    settle();
    chk("t5_stray_wb_valid", 64'(wb_valid), 64'd0);
    chk("t5_stray_ready", 64'(tlb_rd_resp_ready), 64'd1);
    cyc();
    set_resp(1'b0, 0);
    settle();
    chk("t5_err_set", 64'(err_unexp), 64'd1);
    send_cmd(56'h80, 8'd0);
    settle();
    chk("t5_err_cleared", 64'(err_unexp), 64'd0);
    cyc();

    // Request stalled for five cycles
    tlb_rd_req_ready = 1'b0;
    send_cmd(56'h3000, 8'd1);
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("t6_stall_valid", 64'(tlb_rd_req_valid), 64'd1);
      chk("t6_stall_addr", 64'(tlb_rd_req.addr), 64'h3000);
      cyc();
    end
    tlb_rd_req_ready = 1'b1;
    settle();
    chk("t6_req_valid", 64'(tlb_rd_req_valid), 64'd1);
    cyc();
    set_resp(1'b1, 0);
    settle();
`ifdef VP_VLOAD_SEQ_PERF_EN
    chk("t6_perf", 64'(perf_stall_cnt), 64'd5);
`else
    chk("t6_perf", 64'(perf_stall_cnt), 64'd0);
`endif
    chk("t6_req_valid_after", 64'(tlb_rd_req_valid), 64'd0);
    cyc();
    set_resp(1'b0, 0);
    settle();
    chk("t6_done_early", 64'(done), 64'd0);
    cyc();
    settle();
    chk("t6_done", 64'(done), 64'd1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
